// File: rtl/seq_nonrestoring_divider_pkg.sv
// Shared types and sizing helpers for the sequential non-restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_nonrestoring_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 8;

    // Step counter width: counts WIDTH-1 down to 0, so $clog2(WIDTH) bits,
    // never narrower than one bit.
    function automatic int cnt_w(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_nonrestoring_divider_addsub.sv
// Ripple-carry controlled add/subtract row: sum = a + b (ctrl=0) or a - b (ctrl=1).
// Latency: combinational, zero cycles.
// Backpressure: none; pure datapath cell.
module addsub_row #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ctrl,
    output logic [N-1:0] sum
);

    logic [N-1:0] b_eff;
    logic [N-1:0] carry;

    // Subtract is two's complement: invert b and inject the +1 as carry-in.
    assign b_eff = b ^ {N{ctrl}};

    // Ripple chain, one full-adder cell per bit; the final carry-out is
    // discarded because all arithmetic wraps modulo 2^N.
    always_comb begin
        carry    = '0;
        carry[0] = ctrl;
        sum      = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b_eff[i] ^ carry[i];
            if (i < N - 1) begin
                carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
            end
        end
    end

endmodule

// File: rtl/seq_nonrestoring_divider.sv
// Iterative unsigned divider, one quotient bit per cycle, non-restoring algorithm.
// Latency: WIDTH+2 cycles from accepting edge to done; 1 cycle for divide by zero.
// Backpressure: start accepted only while ready (IDLE/DONE); ignored while busy.
module seq_nonrestoring_divider
    import seq_nonrestoring_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_w(WIDTH);

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic [WIDTH:0] p_reg;      // signed partial remainder
    logic [WIDTH:0] d_reg;      // divisor, zero-extended
    logic [WIDTH-1:0] q_reg;    // dividend shifting out, quotient shifting in

    logic [WIDTH:0] p_shift;
    logic [WIDTH:0] as_a;
    logic [WIDTH:0] as_sum;
    logic           as_ctrl;

    assign ready = (state == IDLE) || (state == DONE);
    assign busy  = (state == RUN)  || (state == FIX);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: zero divisor short-circuits straight to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = (divisor != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // One adder row serves both phases: in RUN it takes the shifted remainder
    // and subtracts when the old remainder is non-negative; in FIX it adds D back.
    always_comb begin
        p_shift = {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        as_a    = p_shift;
        as_ctrl = ~p_reg[WIDTH];
        if (state == FIX) begin
            as_a    = p_reg;
            as_ctrl = 1'b0;
        end
    end

    addsub_row #(
        .N(WIDTH + 1)
    ) u_addsub_row (
        .a    (as_a),
        .b    (d_reg),
        .ctrl (as_ctrl),
        .sum  (as_sum)
    );

    // Datapath and result registers; done is a single-cycle pulse on DONE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_reg       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        p_reg       <= '0;
                        q_reg       <= dividend;
                        d_reg       <= {1'b0, divisor};
                        cnt         <= CW'(WIDTH - 1);
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    p_reg <= as_sum;
                    q_reg <= {q_reg[WIDTH-2:0], ~as_sum[WIDTH]};
                    cnt   <= cnt - 1'b1;
                end
                FIX: begin
                    quotient  <= q_reg;
                    remainder <= p_reg[WIDTH] ? as_sum[WIDTH-1:0] : p_reg[WIDTH-1:0];
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
